cpr_flow_ctrl: RTL
==================

# cpr_flow_ctrl

Flow controller for the compressor datapath. It issues `pop_infifo`, `wrt_en` (compress-unit data strobe), `push_cmpfifo` and `pop_cmpfifo`. It tracks words in flight through the fixed-latency compress unit, so the compressed-data FIFO can never overflow. It also throttles the aligner feed on aligner stall or output-FIFO back-pressure, and sequences an explicit drain (flush) of the front half of the pipeline.

## Interface
- `CU_LATENCY`, 3: cycles from `wrt_en` with data to valid `cpr_out`/`tag_out`/`len_out` (≥1).
- `FIFO_RD_LATENCY`, 1: cycles from `pop_infifo` to valid `infifo_out` (≥1).
- `MEM_ADDR_WIDTH`, 8: FIFO address width; depth `DEPTH = 2**MEM_ADDR_WIDTH`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `enable` in 1: level; allow new words from the input FIFO.
- `flush` in 1: single-cycle pulse; drain request.
- `empty_infifo` in 1: input FIFO empty.
- `full_cmpfifo` in 1: compressed FIFO full; used only for the error check.
- `empty_cmpfifo` in 1: compressed FIFO empty.
- `cmpfifo_count` in `MEM_ADDR_WIDTH+1`: compressed FIFO occupancy.
- `aligner_stall` in 1: aligner cannot accept input this cycle.
- `almost_full_outfifo` in 1: output FIFO near full.
- `pop_infifo` out 1: pop the input FIFO.
- `wrt_en` out 1: compress unit input valid.
- `push_cmpfifo` out 1: push compress-unit result.
- `pop_cmpfifo` out 1: feed the aligner.
- `inflight` out `MEM_ADDR_WIDTH+1`: words popped but not yet pushed.
- `busy` out 1: state ≠ IDLE, or `inflight` ≠ 0.
- `flush_done` out 1: one-cycle pulse at drain completion.
- `ovf_err` out 1: sticky; set if `push_cmpfifo` occurs while `full_cmpfifo` is high.

## Operation
- Valid shift register `vsr`, length `P = FIFO_RD_LATENCY + CU_LATENCY`:
  - `vsr[0] <= pop_infifo`; shifts every cycle.
  - The pipeline is non-stallable.
  - `wrt_en = vsr[FIFO_RD_LATENCY-1]`.
  - `push_cmpfifo = vsr[P-1]`.
- `inflight` counter:
  - +1 on pop only, −1 on push only, unchanged on both.
  - Never exceeds `DEPTH`.
- Credit rule: `credit_ok = (cmpfifo_count + inflight + 1) <= DEPTH`. Evaluate it at `MEM_ADDR_WIDTH+2` bits, with no truncation.
- `pop_infifo = (state==RUN || state==DRAIN) && !empty_infifo && credit_ok`.
- `pop_cmpfifo = (state!=IDLE || enable) && !empty_cmpfifo && !aligner_stall && !almost_full_outfifo`.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN when `enable`. IDLE → DRAIN on `flush`; `flush` takes priority.
  - RUN → IDLE when `!enable`. RUN → DRAIN on `flush`; `flush` takes priority.
  - DRAIN ignores `enable` and pops until `empty_infifo`. It moves to DONE when `empty_infifo && inflight==0 && !vsr_any && empty_cmpfifo`.
  - DONE asserts `flush_done` for 1 cycle, then goes to IDLE.
  - `flush` received in DRAIN or DONE is ignored.
- Dropping `enable` in RUN: no new pops from the next cycle. In-flight words still complete and are pushed.
- Reset asserted mid-operation: `vsr`, `inflight`, `ovf_err` and state clear immediately. Datapath contents are discarded; the FIFOs share the same reset.

## Timing
- Reset values: all outputs 0; state IDLE.
- `pop_infifo`, `pop_cmpfifo` and `busy` are combinational from registered state and current FIFO status. `wrt_en`, `push_cmpfifo`, `inflight`, `flush_done` and `ovf_err` are registered or derived from registers only.
- A pop at cycle t gives `wrt_en` at t+`FIFO_RD_LATENCY` and `push_cmpfifo` at t+P.
- Throughput: 1 word/cycle while credit and input are available.
- A simultaneous `cmpfifo` push and pop is legal. The credit check uses registered `cmpfifo_count`, which is conservative by one cycle.
- `enable` deasserted: `pop_infifo` is low from the cycle after state leaves RUN.
- Full-boundary condition: when `cmpfifo_count + inflight == DEPTH`, `pop_infifo` is 0 even if `empty_infifo` is 0.

## Test plan
- Stream, defaults, `enable=1`, 10 words, sinks ready → 10 pops on consecutive cycles; `push_cmpfifo` exactly 4 cycles after each pop; `inflight` peaks at 4 and ends at 0.
- Credit limit, `MEM_ADDR_WIDTH=2`, `aligner_stall=1`, 10 words queued → total pushes = 4, `pop_infifo` held low afterwards, `ovf_err` stays 0. Release the stall → remaining 6 words flow.
- Back-pressure: toggle `almost_full_outfifo` / `aligner_stall` → `pop_cmpfifo=0` in every cycle either is high; the front side still pops until credit runs out.
- Drain: `enable=0` with 3 words queued, then a `flush` pulse → 3 pops, 3 pushes. `flush_done` pulses once after `empty_cmpfifo`, then the state is IDLE with `busy=0`.
- Enable drop mid-stream (5 pops issued) → no further pops; all 5 pushes still occur at +4 cycles.
- Reset mid-stream (`reset=0` with `inflight=3`) → all outputs 0 in the same cycle; after release with `enable=1`, the block resumes with `inflight` starting at 0.

Source files
------------

// File: rtl/cpr_flow_ctrl.sv
// Flow controller for the compressor datapath: input FIFO pops, compress-unit
// strobes, compressed-FIFO push/pop, in-flight credit tracking and drain.
//
// Ports:
//   clk, reset (async active-low)
//   enable, flush             - run level / one-cycle drain request
//   empty_infifo              - input FIFO status
//   full_cmpfifo              - compressed FIFO full (overflow check only)
//   empty_cmpfifo             - compressed FIFO empty
//   cmpfifo_count             - compressed FIFO occupancy
//   aligner_stall             - aligner cannot take a word
//   almost_full_outfifo       - output FIFO back-pressure
//   pop_infifo, wrt_en        - input FIFO pop / compress-unit data strobe
//   push_cmpfifo, pop_cmpfifo - compressed FIFO push / pop
//   inflight                  - words popped but not yet pushed
//   busy, flush_done, ovf_err - status
module cpr_flow_ctrl #(
    parameter int CU_LATENCY      = 3,
    parameter int FIFO_RD_LATENCY = 1,
    parameter int MEM_ADDR_WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      flush,
    input  logic                      empty_infifo,
    input  logic                      full_cmpfifo,
    input  logic                      empty_cmpfifo,
    input  logic [MEM_ADDR_WIDTH:0]   cmpfifo_count,
    input  logic                      aligner_stall,
    input  logic                      almost_full_outfifo,
    output logic                      pop_infifo,
    output logic                      wrt_en,
    output logic                      push_cmpfifo,
    output logic                      pop_cmpfifo,
    output logic [MEM_ADDR_WIDTH:0]   inflight,
    output logic                      busy,
    output logic                      flush_done,
    output logic                      ovf_err
);

    localparam int P  = FIFO_RD_LATENCY + CU_LATENCY;
    localparam int CW = MEM_ADDR_WIDTH + 1;
    localparam int SW = MEM_ADDR_WIDTH + 2;

    // DEPTH expressed at the credit-sum width
    localparam logic [SW-1:0] DEPTH_W = {2'b01, {MEM_ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t         state;
    logic [P-1:0]   vsr;
    logic           vsr_any;
    logic [SW-1:0]  credit_sum;
    logic           credit_ok;
    logic           front_on;

    assign vsr_any      = |vsr;
    assign wrt_en       = vsr[FIFO_RD_LATENCY-1];
    assign push_cmpfifo = vsr[P-1];

    // Credit counts words already in the FIFO plus words still in the
    // pipe, so every pop is guaranteed a slot when it finally lands.
    assign credit_sum = {1'b0, cmpfifo_count}
                      + {1'b0, inflight}
                      + SW'(1);
    assign credit_ok  = (credit_sum <= DEPTH_W);

    assign front_on   = (state == S_RUN) || (state == S_DRAIN);
    assign pop_infifo = front_on && !empty_infifo && credit_ok;

    // Gated by reset so the enable path cannot leak a pop while held
    assign pop_cmpfifo = reset
                      && ((state != S_IDLE) || enable)
                      && !empty_cmpfifo
                      && !aligner_stall
                      && !almost_full_outfifo;

    assign busy = (state != S_IDLE) || (inflight != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vsr <= '0;
        end else begin
            vsr <= {vsr[P-2:0], pop_infifo};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight <= '0;
        end else begin
            unique case ({pop_infifo, push_cmpfifo})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_err <= 1'b0;
        end else if (push_cmpfifo && full_cmpfifo) begin
            ovf_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (flush)
                        state <= S_DRAIN;
                    else if (enable)
                        state <= S_RUN;
                end
                S_RUN: begin
                    if (flush)
                        state <= S_DRAIN;
                    else if (!enable)
                        state <= S_IDLE;
                end
                S_DRAIN: begin
                    if (empty_infifo && (inflight == '0)
                        && !vsr_any && empty_cmpfifo) begin
                        state      <= S_DONE;
                        flush_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
